// File: rtl/digclk_pkg.sv
// Shared constants and helpers for the digital clock: BCD digit width, digit limits, hour limits.
package digclk_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned HOUR_MAX_DEFAULT = 23;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t SEC_L_MAX = 4'd9;
    localparam bcd_t SEC_H_MAX = 4'd5;
    localparam bcd_t MIN_L_MAX = 4'd9;
    localparam bcd_t MIN_H_MAX = 4'd5;
    localparam bcd_t HR_L_MAX  = 4'd9;

    // Full HH:MM:SS count, most significant digit first.
    typedef struct packed {
        bcd_t hr_h;
        bcd_t hr_l;
        bcd_t min_h;
        bcd_t min_l;
        bcd_t sec_h;
        bcd_t sec_l;
    } hms_t;

    // Tens and units digits of the top hour value.
    function automatic bcd_t hr_h_lim(input int unsigned hour_max);
        return bcd_t'(hour_max / 32'd10);
    endfunction

    function automatic bcd_t hr_l_lim(input int unsigned hour_max);
        return bcd_t'(hour_max % 32'd10);
    endfunction

    // Single BCD digit increment that wraps to 0 after max.
    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max);
        return (d == max) ? '0 : bcd_t'(d + 4'd1);
    endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Synchroniser chain plus registered rising-edge pulse; a level already high
// when reset releases is ignored until it has been seen low.
module edge_sync_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_valid;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_pulse;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign o_pulse    = r_pulse;

    // r_valid tracks when the chain output holds a real post-reset sample,
    // so arming only happens once a genuine low has been observed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_valid <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_sync_out;
            r_armed <= r_armed | (r_valid[SYNC_STAGES-1] & ~w_sync_out);
            r_pulse <= w_sync_out & ~r_prev & r_armed;
        end
    end

endmodule

// File: rtl/time_count_core.sv
// 24-hour BCD HH:MM:SS time-keeping core driven by a synchronised divider tick.
// Optional hourly chime output enabled by defining HOURLY_CHIME_EN.
module time_count_core
    import digclk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOUR_MAX    = HOUR_MAX_DEFAULT
) (
    input  logic               CP,
    input  logic               CR,
    input  logic               clk_in,
    input  logic               run_en,
    input  logic               adj_min,
    input  logic               adj_hr,
    output logic [DIGIT_W-1:0] sec_l,
    output logic [DIGIT_W-1:0] sec_h,
    output logic [DIGIT_W-1:0] min_l,
    output logic [DIGIT_W-1:0] min_h,
    output logic [DIGIT_W-1:0] hr_l,
    output logic [DIGIT_W-1:0] hr_h,
    output logic               tick,
    output logic               day_pulse,
    output logic               chime
);

    localparam bcd_t HR_H_LIM = hr_h_lim(HOUR_MAX);
    localparam bcd_t HR_L_LIM = hr_l_lim(HOUR_MAX);

    hms_t r_t;
    hms_t w_nxt;
    logic r_day;
    logic w_tick;
    logic w_sec59;
    logic w_min59;
    logic w_hr_top;
    logic w_adv;
    logic w_min_step;
    logic w_hr_step;
    logic w_day;

    edge_sync_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .i_clk   (CP),
        .i_rst   (CR),
        .i_d     (clk_in),
        .o_pulse (w_tick)
    );

    // Next-count logic; any adjust pulse suppresses the tick's advance.
    always_comb begin
        w_nxt      = r_t;
        w_sec59    = (r_t.sec_h == SEC_H_MAX) && (r_t.sec_l == SEC_L_MAX);
        w_min59    = (r_t.min_h == MIN_H_MAX) && (r_t.min_l == MIN_L_MAX);
        w_hr_top   = (r_t.hr_h == HR_H_LIM) && (r_t.hr_l == HR_L_LIM);
        w_adv      = w_tick & run_en & ~adj_min & ~adj_hr;
        w_min_step = (w_adv & w_sec59) | adj_min;
        w_hr_step  = (w_adv & w_sec59 & w_min59) | adj_hr;
        w_day      = w_adv & w_sec59 & w_min59 & w_hr_top;

        if (w_adv) begin
            w_nxt.sec_l = bcd_inc(r_t.sec_l, SEC_L_MAX);
            if (r_t.sec_l == SEC_L_MAX)
                w_nxt.sec_h = bcd_inc(r_t.sec_h, SEC_H_MAX);
        end

        if (w_min_step) begin
            w_nxt.min_l = bcd_inc(r_t.min_l, MIN_L_MAX);
            if (r_t.min_l == MIN_L_MAX)
                w_nxt.min_h = bcd_inc(r_t.min_h, MIN_H_MAX);
        end

        if (w_hr_step) begin
            if (w_hr_top) begin
                w_nxt.hr_h = '0;
                w_nxt.hr_l = '0;
            end else begin
                w_nxt.hr_l = bcd_inc(r_t.hr_l, HR_L_MAX);
                if (r_t.hr_l == HR_L_MAX)
                    w_nxt.hr_h = bcd_t'(r_t.hr_h + 4'd1);
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            r_t   <= '0;
            r_day <= 1'b0;
        end else begin
            r_t   <= w_nxt;
            r_day <= w_day;
        end
    end

`ifdef HOURLY_CHIME_EN
    logic r_chime;
    logic w_chime_c;

    // Last five seconds of each hour plus the top of the hour itself.
    always_comb begin
        w_chime_c = 1'b0;
        if (w_min59 && (r_t.sec_h == SEC_H_MAX) && (r_t.sec_l >= 4'd5))
            w_chime_c = 1'b1;
        if ((r_t.min_h == 4'd0) && (r_t.min_l == 4'd0) &&
            (r_t.sec_h == 4'd0) && (r_t.sec_l == 4'd0))
            w_chime_c = 1'b1;
    end

    always_ff @(posedge CP) begin
        if (CR)
            r_chime <= 1'b0;
        else
            r_chime <= w_chime_c;
    end

    assign chime = r_chime;
`else
    assign chime = 1'b0;
`endif

    assign sec_l     = r_t.sec_l;
    assign sec_h     = r_t.sec_h;
    assign min_l     = r_t.min_l;
    assign min_h     = r_t.min_h;
    assign hr_l      = r_t.hr_l;
    assign hr_h      = r_t.hr_h;
    assign tick      = w_tick;
    assign day_pulse = r_day;

endmodule

// File: tb/tb_time_count_core.sv
// Directed self-checking bench for time_count_core (default 24-hour, 2-stage sync).
module tb_time_count_core;

    logic       CP;
    logic       CR;
    logic       clk_in;
    logic       run_en;
    logic       adj_min;
    logic       adj_hr;
    logic [3:0] sec_l, sec_h, min_l, min_h, hr_l, hr_h;
    logic       tick;
    logic       day_pulse;
    logic       chime;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;
    int day_cnt  = 0;
    int day_zero = 0;

    logic [23:0] w_time;
    assign w_time = {hr_h, hr_l, min_h, min_l, sec_h, sec_l};

    time_count_core dut (
        .CP        (CP),
        .CR        (CR),
        .clk_in    (clk_in),
        .run_en    (run_en),
        .adj_min   (adj_min),
        .adj_hr    (adj_hr),
        .sec_l     (sec_l),
        .sec_h     (sec_h),
        .min_l     (min_l),
        .min_h     (min_h),
        .hr_l      (hr_l),
        .hr_h      (hr_h),
        .tick      (tick),
        .day_pulse (day_pulse),
        .chime     (chime)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally the pulse outputs.
    task automatic step();
        @(negedge CP);
        if (tick) tick_cnt++;
        if (day_pulse) begin
            day_cnt++;
            if (w_time == 24'h000000) day_zero++;
        end
    endtask

    task automatic clk_period();
        clk_in = 1'b1;
        repeat (4) step();
        clk_in = 1'b0;
        repeat (4) step();
    endtask

    task automatic periods(input int n);
        for (int i = 0; i < n; i++) clk_period();
    endtask

    task automatic adj(input logic m, input logic h);
        adj_min = m;
        adj_hr  = h;
        step();
        adj_min = 1'b0;
        adj_hr  = 1'b0;
        step();
    endtask

    task automatic adj_n(input int mins, input int hrs);
        for (int i = 0; i < hrs; i++) adj(1'b0, 1'b1);
        for (int i = 0; i < mins; i++) adj(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        CR = 1'b1;
        repeat (2) step();
        CR = 1'b0;
        repeat (4) step();
    endtask

    logic [23:0] exp_t [7] = '{24'h005955, 24'h005956, 24'h005957, 24'h005958,
                               24'h005959, 24'h010000, 24'h010001};
    logic        exp_c [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        CR = 1'b1; clk_in = 1'b0; run_en = 1'b0; adj_min = 1'b0; adj_hr = 1'b0;
        repeat (3) step();
        check("rst_time", 32'(w_time), 32'h000000);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_day", 32'(day_pulse), 32'd0);
        check("rst_chime", 32'(chime), 32'd0);
        CR = 1'b0;
        run_en = 1'b1;
        repeat (4) step();

        // Latency from first high sample to tick and digit update.
        tick_cnt = 0;
        clk_in = 1'b1;
        step(); check("lat_e1_tick", 32'(tick), 32'd0);
        step(); check("lat_e2_tick", 32'(tick), 32'd0);
        step(); check("lat_e3_tick", 32'(tick), 32'd1);
        check("lat_e3_time", 32'(w_time), 32'h000000);
        step(); check("lat_e4_tick", 32'(tick), 32'd0);
        check("lat_e4_time", 32'(w_time), 32'h000001);
        clk_in = 1'b0;
        repeat (4) step();
        periods(3);
        check("count4_time", 32'(w_time), 32'h000004);
        check("count4_ticks", 32'(tick_cnt), 32'd4);

        // Day rollover.
        do_reset();
        adj_n(59, 23);
        check("preload_2359", 32'(w_time), 32'h235900);
        periods(59);
        check("t_235959", 32'(w_time), 32'h235959);
        day_cnt = 0; day_zero = 0;
        periods(1);
        check("wrap_time", 32'(w_time), 32'h000000);
        check("wrap_day_cnt", 32'(day_cnt), 32'd1);
        check("wrap_day_zero", 32'(day_zero), 32'd1);

        // Minute adjust wraps without carry; hour adjust wraps without day pulse.
        do_reset();
        adj_n(59, 12);
        periods(30);
        check("t_125930", 32'(w_time), 32'h125930);
        adj(1'b1, 1'b0);
        check("adjmin_wrap", 32'(w_time), 32'h120030);
        do_reset();
        adj_n(10, 23);
        check("t_231000", 32'(w_time), 32'h231000);
        day_cnt = 0;
        adj(1'b0, 1'b1);
        check("adjhr_wrap", 32'(w_time), 32'h001000);
        check("adjhr_no_day", 32'(day_cnt), 32'd0);

        // Both adjusts together.
        adj(1'b1, 1'b1);
        check("adj_both", 32'(w_time), 32'h011100);

        // Adjust colliding with tick, then frozen counting.
        do_reset();
        adj_n(5, 0);
        periods(7);
        check("t_000507", 32'(w_time), 32'h000507);
        clk_in = 1'b1;
        repeat (3) step();
        check("collide_tick", 32'(tick), 32'd1);
        adj_min = 1'b1;
        step();
        adj_min = 1'b0;
        check("collide_time", 32'(w_time), 32'h000607);
        repeat (3) step();
        clk_in = 1'b0;
        repeat (4) step();
        run_en = 1'b0;
        tick_cnt = 0;
        periods(3);
        check("frozen_time", 32'(w_time), 32'h000607);
        check("frozen_ticks", 32'(tick_cnt), 32'd3);
        run_en = 1'b1;

        // clk_in high through reset release must not tick.
        clk_in = 1'b1;
        CR = 1'b1;
        repeat (2) step();
        CR = 1'b0;
        tick_cnt = 0;
        repeat (8) step();
        check("hi_rst_no_tick", 32'(tick_cnt), 32'd0);
        clk_in = 1'b0;
        repeat (4) step();
        clk_in = 1'b1;
        repeat (4) step();
        clk_in = 1'b0;
        repeat (4) step();
        check("hi_rst_retick", 32'(tick_cnt), 32'd1);
        check("hi_rst_time", 32'(w_time), 32'h000001);

        // Reset beats adjust mid-count.
        do_reset();
        adj_n(42, 0);
        periods(17);
        check("t_004217", 32'(w_time), 32'h004217);
        CR = 1'b1;
        adj_min = 1'b1;
        step();
        check("rst_wins", 32'(w_time), 32'h000000);
        CR = 1'b0;
        adj_min = 1'b0;
        repeat (4) step();

        // Chime around the top of the hour.
        do_reset();
        adj_n(59, 0);
        periods(54);
        check("t_005954", 32'(w_time), 32'h005954);
        check("chime_54", 32'(chime), 32'd0);
        for (int i = 0; i < 7; i++) begin
            clk_period();
            check("chime_time", 32'(w_time), 32'(exp_t[i]));
`ifdef HOURLY_CHIME_EN
            check("chime_on", 32'(chime), 32'(exp_c[i]));
`else
            check("chime_off", 32'(chime), 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
